// File: rtl/vga_rx_if.sv
// ---------------------------------------------------------------------------
// vga_rx_if
// Bundle carrying the VGA timing bus from a display controller to a receiver.
//   HS      : horizontal sync, active-low pulse
//   VS      : vertical sync, active-low pulse
//   R, G, B : 4-bit colour components
// Modports:
//   master : the timing generator, drives every signal
//   slave  : the receiver, samples every signal
// ---------------------------------------------------------------------------
interface vga_rx_if;
    logic       HS;
    logic       VS;
    logic [3:0] R;
    logic [3:0] G;
    logic [3:0] B;

    modport master (output HS, output VS, output R, output G, output B);
    modport slave  (input  HS, input  VS, input  R, input  G, input  B);
endinterface

// File: rtl/vga_rx.sv
// ---------------------------------------------------------------------------
// vga_rx
// Receiving end of a VGA timing bus in the pixel clock domain. Recovers the
// horizontal/vertical position from HS/VS, checks line and frame lengths,
// tracks timing lock and emits the active pixels with their coordinates.
//
// Ports:
//   clk         : pixel clock
//   rst         : asynchronous reset, active-high
//   vga         : VGA bus (HS, VS, R, G, B), slave side
//   pix_valid   : pix_x/pix_y/pix_data valid this cycle
//   pix_x       : active column 0..H_ACTIVE-1
//   pix_y       : active row 0..V_ACTIVE-1
//   pix_data    : {B, G, R}
//   frame_start : one-cycle pulse with pixel (0,0)
//   locked      : timing lock
//   line_err    : one-cycle pulse when a line was not H_TOTAL clocks long
//   frame_err   : one-cycle pulse when a frame was not V_TOTAL lines long
// ---------------------------------------------------------------------------
module vga_rx #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_START     = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    vga_rx_if.slave     vga,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_data,
    output logic        frame_start,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_SEARCH   = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam int GOOD_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_FRAMES);

    localparam logic [9:0]  CNT_MAX  = 10'd1023;
    localparam logic [10:0] H_LEN    = 11'(H_TOTAL);
    localparam logic [10:0] V_LEN    = 11'(V_TOTAL);
    localparam logic [9:0]  H_FIRST  = 10'(H_START);
    localparam logic [9:0]  H_LAST   = 10'(H_START + H_ACTIVE - 1);
    localparam logic [9:0]  V_FIRST  = 10'(V_START);
    localparam logic [9:0]  V_LAST   = 10'(V_START + V_ACTIVE - 1);

    // ---------------- input stage ----------------
    logic       hs_q, vs_q, hs_qq, vs_qq;
    logic [3:0] r_q, g_q, b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            hs_qq <= 1'b1;
            vs_qq <= 1'b1;
            r_q   <= 4'd0;
            g_q   <= 4'd0;
            b_q   <= 4'd0;
        end else begin
            hs_q  <= vga.HS;
            vs_q  <= vga.VS;
            hs_qq <= hs_q;
            vs_qq <= vs_q;
            r_q   <= vga.R;
            g_q   <= vga.G;
            b_q   <= vga.B;
        end
    end

    logic hs_fall, vs_fall, restart;

    assign hs_fall = hs_qq & ~hs_q;
    assign vs_fall = vs_qq & ~vs_q;

    // ---------------- position counters ----------------
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        vs_pend_q, vs_pend_d;     // VS fell earlier in the current line
    logic        hs_seen_q, hs_seen_d;     // a line start has been seen since reset
    logic        frame_seen_q, frame_seen_d; // a frame start has been seen since reset
    logic [10:0] line_len, frame_len;

    // A VS fall anywhere in a line is folded into the next HS fall, so the
    // frame restart always lands on a line boundary.
    assign restart   = hs_fall & (vs_fall | vs_pend_q);
    assign line_len  = {1'b0, hcnt_q} + 11'd1;
    assign frame_len = {1'b0, vcnt_q} + 11'd1;

    always_comb begin
        if (hs_fall) begin
            hcnt_d = 10'd0;
        end else if (hcnt_q == CNT_MAX) begin
            hcnt_d = hcnt_q;
        end else begin
            hcnt_d = hcnt_q + 10'd1;
        end

        vcnt_d = vcnt_q;
        if (restart) begin
            vcnt_d = 10'd0;
        end else if (hs_fall && (vcnt_q != CNT_MAX)) begin
            vcnt_d = vcnt_q + 10'd1;
        end

        vs_pend_d    = hs_fall ? 1'b0 : (vs_pend_q | vs_fall);
        hs_seen_d    = hs_seen_q | hs_fall;
        frame_seen_d = frame_seen_q | restart;
    end

    // ---------------- length checks ----------------
    // The very first line/frame after reset is usually partial, so a check
    // only arms after one boundary has been observed.
    logic line_err_d, frame_err_d, any_err;

    assign line_err_d  = hs_fall & hs_seen_q & (line_len != H_LEN);
    assign frame_err_d = restart & frame_seen_q & (frame_len != V_LEN);
    assign any_err     = line_err_d | frame_err_d;

    // ---------------- lock FSM ----------------
    logic [1:0]        state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic              frame_bad_q, frame_bad_d; // current frame already saw an error

    assign good_inc = good_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        frame_bad_d = restart ? 1'b0 : (frame_bad_q | any_err);

        case (state_q)
            ST_UNLOCKED: begin
                good_d = '0;
                if (vs_fall) begin
                    state_d = ST_SEARCH;
                    // A VS fall ahead of its line boundary leaves a partial
                    // frame pending; it must not count as a good one.
                    if (!restart) begin
                        frame_bad_d = 1'b1;
                    end
                end
            end
            ST_SEARCH: begin
                if (any_err) begin
                    good_d = '0;
                end else if (restart && !frame_bad_q) begin
                    good_d = good_inc;
                    if (good_inc == GOOD_TARGET) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (any_err) begin
                    state_d = ST_UNLOCKED;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                good_d  = '0;
            end
        endcase
    end

    // ---------------- pixel output ----------------
    logic        h_active, v_active;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [11:0] pix_data_q, pix_data_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, line_err_q, frame_err_q;

    assign h_active = (hcnt_q >= H_FIRST) && (hcnt_q <= H_LAST);
    assign v_active = (vcnt_q >= V_FIRST) && (vcnt_q <= V_LAST);

    always_comb begin
        pix_valid_d   = (state_q == ST_LOCKED) && h_active && v_active;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_data_d    = pix_data_q;
        if (pix_valid_d) begin
            pix_x_d    = hcnt_q - H_FIRST;
            pix_y_d    = vcnt_q - V_FIRST;
            pix_data_d = {b_q, g_q, r_q};
        end
        frame_start_d = pix_valid_d && (hcnt_q == H_FIRST) && (vcnt_q == V_FIRST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            vs_pend_q     <= 1'b0;
            hs_seen_q     <= 1'b0;
            frame_seen_q  <= 1'b0;
            state_q       <= ST_UNLOCKED;
            good_q        <= '0;
            frame_bad_q   <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_data_q    <= 12'd0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            vs_pend_q     <= vs_pend_d;
            hs_seen_q     <= hs_seen_d;
            frame_seen_q  <= frame_seen_d;
            state_q       <= state_d;
            good_q        <= good_d;
            frame_bad_q   <= frame_bad_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
            locked_q      <= (state_d == ST_LOCKED);
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_data    = pix_data_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: doc/vga_rx.md
Name: vga_rx

Overview:
- Receiving end of the VGA timing interface driven by the display controller: consumes HS, VS and 12-bit RGB, recovers horizontal and vertical position, and emits a stream of active pixels with coordinates.
- Checks line and frame lengths, and reports lock and error status.
- Used as an on-chip loopback checker or capture front-end feeding a frame-capture RAM.
- Same pixel clock domain as the VGA generator (25 MHz).

Parameters:
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- H_START, 144, hcnt value of the first active pixel, aligned to the generator's registered RGB
- H_ACTIVE, 640, active pixels per line
- V_START, 35, vcnt value of the first active line
- V_ACTIVE, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- HS  in  1  horizontal sync, active-low pulse
- VS  in  1  vertical sync, active-low pulse
- R  in  4  red
- G  in  4  green
- B  in  4  blue
- pix_valid  out  1  pixel_x/pixel_y/pix_data valid this cycle
- pix_x  out  10  column 0..H_ACTIVE-1
- pix_y  out  10  row 0..V_ACTIVE-1
- pix_data  out  12  bbbb_gggg_rrrr
- frame_start  out  1  one-cycle pulse on the first active pixel of a frame (pixel 0,0)
- locked  out  1  timing lock
- line_err  out  1  one-cycle pulse when a line length is not H_TOTAL
- frame_err  out  1  one-cycle pulse when a frame length is not V_TOTAL

Behaviour:
- Reset (async): all outputs 0; hcnt, vcnt, line/frame length counters, good-frame counter 0; input regs HS_q=1, VS_q=1, HS_qq=1, VS_qq=1; FSM = UNLOCKED.
- Input stage: HS, VS, R, G, B registered every clk into *_q; HS_qq/VS_qq hold the previous *_q for edge detection.
- hs_fall = HS_qq & ~HS_q; vs_fall = VS_qq & ~VS_q.
- hcnt (10b): cleared to 0 on hs_fall, otherwise increments; saturates at 1023, never wraps.
- vcnt (10b): on hs_fall, cleared to 0 if vs_fall or (VS_q==0 and VS_qq==1 seen since last hs_fall); otherwise incremented, saturating at 1023.
  - VS falling within the same line as an HS falling edge is treated as simultaneous.
- Line length check: on hs_fall, if previous hcnt+1 != H_TOTAL and at least one hs_fall has been seen since reset → line_err=1 for one cycle.
- Frame length check: on a frame restart (vcnt clear), if previous vcnt+1 != V_TOTAL and at least one VS edge has been seen since reset → frame_err=1 for one cycle.
- FSM:
  - UNLOCKED→SEARCH on first vs_fall.
  - SEARCH: good-frame counter increments on each frame restart without line_err/frame_err in that frame; → LOCKED when the count reaches LOCK_FRAMES.
  - Any line_err or frame_err in SEARCH clears the counter (stays SEARCH).
  - LOCKED: locked=1; any line_err or frame_err → UNLOCKED, counter cleared, locked=0 on the next cycle.
- Pixel output (registered, 1 cycle after the input-register stage, so 2 clk after the pin):
  - pix_valid=1 iff locked, hcnt in [H_START, H_START+H_ACTIVE-1], and vcnt in [V_START, V_START+V_ACTIVE-1].
  - pix_x = hcnt-H_START; pix_y = vcnt-V_START; pix_data = {B_q,G_q,R_q}.
  - When pix_valid=0, pix_x/pix_y/pix_data hold their last values.
- frame_start = pix_valid with pix_x==0 and pix_y==0.
- Exactly H_ACTIVE*V_ACTIVE = 307200 pix_valid cycles per locked frame.
- Mid-operation reset returns everything to reset values immediately; the first post-reset edges raise no errors.
- Errors only pulse; no sticky state beyond the FSM.

Test Plan:
- Drive the VGA generator (800x525, constant Din=12'hA5C) from reset → locked rises after 2 full frames; then 307200 pix_valid cycles per frame, all pix_data=12'hA5C.
- Generator with Din = {2'b0,PCol[9:0]} → every valid pixel has pix_data[9:0]==pix_x+143 (generator column offset); frame_start coincides with pix_x=0, pix_y=0, and pix_x reaches 639, pix_y reaches 479.
- Locked, then one line shortened to 799 clocks → line_err pulses once on the next hs_fall, locked falls next cycle, pix_valid stays 0 until 2 good frames later.
- Locked, then a frame of 524 lines → frame_err pulses once, locked drops, relocks after 2 frames.
- rst asserted mid-line while locked → all outputs 0 asynchronously; after release, no line_err/frame_err on the first partial line/frame.
- HS and VS held high (no sync) → locked stays 0, pix_valid 0, no error pulses, hcnt saturates without wrap.
